// File: rtl/mult_share_arbiter_if.sv
// Bundle of the requester, multiplier and response signals around the
// shared-multiplier arbiter. The arbiter uses the slave modport; the
// requesters, multiplier and response consumer use the master modport.
interface mult_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done;
    logic [2*W-1:0]    mul_prod;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_prod;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, mul_done, mul_prod, rsp_ready,
        output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, mul_done, mul_prod, rsp_ready,
        input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_prod, rsp_err
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one start/done multiplier among NREQ requesters.
// One multiply in flight; the product (or a timeout error) is returned on a
// valid/ready response channel tagged with the requester index.
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                rst,
    mult_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  idx;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_q, b_q;
    logic [IDW-1:0]  id_q;
    logic [2*W-1:0]  prod_q;
    logic            err_q;
    logic [NREQ-1:0] req_ready;
    logic            mul_start;
    logic            accept;
    logic            done_hit;
    logic            timeout_hit;

    // Round-robin pick: first valid requester scanning from ptr upwards, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Next-state and control outputs of the IDLE/ISSUE/WAIT/RESP controller.
    always_comb begin
        state_n     = state;
        req_ready   = '0;
        mul_start   = 1'b0;
        accept      = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                // Held off while rst is high so outputs read zero during reset.
                if (found && !rst) begin
                    req_ready[sel] = 1'b1;
                    accept         = 1'b1;
                    state_n        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                // done has priority over a timeout landing in the same cycle.
                if (bus.mul_done) begin
                    done_hit = 1'b1;
                    state_n  = S_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Operand latch, timeout counter, response capture and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset because they drive module outputs directly.
        if (rst) begin
            ptr    <= '0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= bus.req_a[int'(sel)*W +: W];
                b_q  <= bus.req_b[int'(sel)*W +: W];
                id_q <= sel;
            end
            if (state == S_ISSUE) begin
                cnt <= '0;
            end
            if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
                if (done_hit) begin
                    prod_q <= bus.mul_prod;
                    err_q  <= 1'b0;
                end else if (timeout_hit) begin
                    prod_q <= '0;
                    err_q  <= 1'b1;
                end
            end
            if (state == S_RESP && bus.rsp_ready) begin
                ptr <= IDW'((int'(id_q) + 1) % NREQ);
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mul_start = mul_start;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_prod  = prod_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: directed requests push expected
// responses; a monitor pops and compares on every response handshake.
module tb_mult_share_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic clk = 1'b0;
    logic rst;

    mult_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2*W-1:0] prod;
        logic           err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Multiplier model: done raised in WAIT cycle number done_at (0 = never).
    int          done_at   = 0;
    bit          m_active  = 1'b0;
    int          m_idx     = 0;
    logic [31:0] m_prod    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [31:0] prod, input logic err);
        rsp_t e;
        e.id   = IDW'(id);
        e.prod = prod;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Present one request and return in the ISSUE cycle after the handshake.
    task automatic accept(input int id, input logic [15:0] a, input logic [15:0] b);
        int c;
        c = 0;
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_valid[id]    = 1'b1;
        #1;
        while (!bus.req_ready[id] && c < 200) begin
            tick();
            c++;
        end
        check($sformatf("grant_%0d", id), 64'(bus.req_ready), 64'(1 << id));
        tick();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            tick();
            c++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_mul_start"}, 64'(bus.mul_start), 64'd0);
        check({tag, "_mul_a"},     64'(bus.mul_a),     64'd0);
        check({tag, "_mul_b"},     64'(bus.mul_b),     64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
        check({tag, "_rsp_prod"},  64'(bus.rsp_prod),  64'd0);
        check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
    endtask

    // Multiplier model driven on the falling edge.
    initial begin
        bus.mul_done = 1'b0;
        bus.mul_prod = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (rst) begin
                m_active = 1'b0;
            end else if (bus.mul_start) begin
                m_active = 1'b1;
                m_idx    = 0;
                m_prod   = 32'(bus.mul_a) * 32'(bus.mul_b);
            end else if (m_active) begin
                m_idx++;
                if (m_idx == done_at) begin
                    bus.mul_done = 1'b1;
                    bus.mul_prod = m_prod;
                    m_active     = 1'b0;
                end
            end
        end
    end

    // Response monitor: compare every handshake against the scoreboard head.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
                check("rsp_prod", 64'(bus.rsp_prod), 64'(e.prod));
                check("rsp_err",  64'(bus.rsp_err),  64'(e.err));
            end
        end
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          order [5];
        logic [31:0] prods [4];
        int          c;

        order = '{0, 1, 2, 3, 0};
        prods = '{32'd21, 32'd20000, 32'h2468, 32'hFFFF};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // All four requesters held high: round-robin 0,1,2,3,0.
        done_at = 3;
        bus.req_a = {16'hFFFF, 16'h1234, 16'd100, 16'd3};
        bus.req_b = {16'd1,    16'd2,    16'd200, 16'd7};
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            c = 0;
            while (bus.req_ready == '0 && c < 200) begin
                tick();
                c++;
            end
            check($sformatf("rr_grant_%0d", k), 64'(bus.req_ready), 64'(1 << order[k]));
            push_exp(order[k], prods[order[k]], 1'b0);
            tick();
            check($sformatf("rr_pulse_%0d", k), 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = '0;
        wait_drain();

        // Single request 3*5, done on WAIT cycle 17.
        done_at = 17;
        push_exp(0, 32'd15, 1'b0);
        accept(0, 16'd3, 16'd5);
        check("t1_start",  64'(bus.mul_start), 64'd1);
        check("t1_mul_a",  64'(bus.mul_a),     64'd3);
        check("t1_mul_b",  64'(bus.mul_b),     64'd5);
        tick();
        check("t1_start_pulse", 64'(bus.mul_start), 64'd0);
        repeat (16) tick();
        check("t1_no_rsp_at_done", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("t1_rsp_after_done", 64'(bus.rsp_valid), 64'd1);
        wait_drain();

        // Response back-pressure: outputs held, no grant, no start.
        bus.rsp_ready = 1'b0;
        done_at = 2;
        push_exp(1, 32'd42, 1'b0);
        accept(1, 16'd6, 16'd7);
        c = 0;
        while (!bus.rsp_valid && c < 100) begin
            tick();
            c++;
        end
        bus.req_a[2*W +: W] = 16'd2;
        bus.req_b[2*W +: W] = 16'd2;
        bus.req_valid[2]    = 1'b1;
        push_exp(2, 32'd4, 1'b0);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("t3_rsp_id",    64'(bus.rsp_id),    64'd1);
            check("t3_rsp_prod",  64'(bus.rsp_prod),  64'd42);
            check("t3_rsp_err",   64'(bus.rsp_err),   64'd0);
            check("t3_req_ready", 64'(bus.req_ready), 64'd0);
            check("t3_mul_start", 64'(bus.mul_start), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("t3_reaccept", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid[2] = 1'b0;
        wait_drain();

        // Multiplier never finishes: error after 64 WAIT cycles.
        done_at = 0;
        push_exp(3, 32'd0, 1'b1);
        accept(3, 16'd9, 16'd9);
        repeat (TIMEOUT) tick();
        check("t4_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t4_rsp_err",   64'(bus.rsp_err),   64'd1);
        wait_drain();
        done_at = 5;
        push_exp(0, 32'd6, 1'b0);
        accept(0, 16'd2, 16'd3);
        wait_drain();

        // Full-scale operands, then done coinciding with the timeout.
        done_at = 10;
        push_exp(1, 32'hFFFE0001, 1'b0);
        accept(1, 16'hFFFF, 16'hFFFF);
        wait_drain();
        done_at = TIMEOUT;
        push_exp(2, 32'h00015F90, 1'b0);
        accept(2, 16'd300, 16'd300);
        wait_drain();

        // Reset in WAIT: transaction abandoned, pointer back to 0.
        done_at = 0;
        accept(0, 16'd4, 16'd4);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_zero_outputs("t5");
        rst = 1'b0;
        done_at = 4;
        bus.req_a[1*W +: W] = 16'd5;
        bus.req_b[1*W +: W] = 16'd5;
        bus.req_a[3*W +: W] = 16'd7;
        bus.req_b[3*W +: W] = 16'd7;
        bus.req_valid = 4'b1010;
        #1;
        check("t5_ptr_reset_grant", 64'(bus.req_ready), 64'b0010);
        push_exp(1, 32'd25, 1'b0);
        tick();
        bus.req_valid = '0;
        wait_drain();

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
